// File: rtl/stage_instruction_decode_pkg.sv
// Shared types for the instruction-decode stage.
//   XLEN / ILEN / REG_IDX_W : architectural widths
//   opcode_t                : decoded major opcode, OPCODE_UNKNOWN marks an illegal word
//   imm_format_t            : immediate layout selector for the immediate generator
//   extract_opcode()        : raw instr[6:0] -> opcode_t
//   imm_format_of()         : opcode_t -> imm_format_t
package stage_instruction_decode_pkg;

    localparam int XLEN      = 32;
    localparam int ILEN      = 32;
    localparam int REG_IDX_W = 5;

    // OPCODE_UNKNOWN is encoded as zero so the reset value of the latched
    // opcode is all-zeros like every other decoded field.
    typedef enum logic [3:0] {
        OPCODE_UNKNOWN = 4'd0,
        OPCODE_LUI     = 4'd1,
        OPCODE_AUIPC   = 4'd2,
        OPCODE_JAL     = 4'd3,
        OPCODE_JALR    = 4'd4,
        OPCODE_BRANCH  = 4'd5,
        OPCODE_LOAD    = 4'd6,
        OPCODE_STORE   = 4'd7,
        OPCODE_OP_IMM  = 4'd8,
        OPCODE_OP      = 4'd9
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_format_t;

    function automatic opcode_t extract_opcode(input logic [6:0] op_bits);
        opcode_t op;
        case (op_bits)
            7'b0110111: op = OPCODE_LUI;
            7'b0010111: op = OPCODE_AUIPC;
            7'b1101111: op = OPCODE_JAL;
            7'b1100111: op = OPCODE_JALR;
            7'b1100011: op = OPCODE_BRANCH;
            7'b0000011: op = OPCODE_LOAD;
            7'b0100011: op = OPCODE_STORE;
            7'b0010011: op = OPCODE_OP_IMM;
            7'b0110011: op = OPCODE_OP;
            default:    op = OPCODE_UNKNOWN;
        endcase
        return op;
    endfunction

    function automatic imm_format_t imm_format_of(input opcode_t op);
        imm_format_t fmt;
        case (op)
            OPCODE_OP_IMM,
            OPCODE_LOAD,
            OPCODE_JALR:   fmt = IMM_I;
            OPCODE_STORE:  fmt = IMM_S;
            OPCODE_BRANCH: fmt = IMM_B;
            OPCODE_LUI,
            OPCODE_AUIPC:  fmt = IMM_U;
            OPCODE_JAL:    fmt = IMM_J;
            default:       fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/stage_instruction_decode_immediate_generator.sv
// Combinational immediate generator for the decode stage.
//   i_instr_bits : raw instruction word
//   i_imm_format : immediate layout chosen from the opcode
//   o_imm        : sign-extended (or upper) immediate, zero for R-type
module stage_instruction_decode_immediate_generator
    import stage_instruction_decode_pkg::*;
(
    input  logic [ILEN-1:0] i_instr_bits,
    input  imm_format_t     i_imm_format,
    output logic [XLEN-1:0] o_imm
);

    // Opcode bits never reach the immediate; the format already encodes them.
    logic w_unused_opcode_bits;
    assign w_unused_opcode_bits = ^i_instr_bits[6:0];

    always_comb begin
        o_imm = '0;
        case (i_imm_format)
            IMM_I: o_imm = {{20{i_instr_bits[31]}}, i_instr_bits[31:20]};
            IMM_S: o_imm = {{20{i_instr_bits[31]}}, i_instr_bits[31:25], i_instr_bits[11:7]};
            IMM_B: o_imm = {{19{i_instr_bits[31]}}, i_instr_bits[31], i_instr_bits[7],
                            i_instr_bits[30:25], i_instr_bits[11:8], 1'b0};
            IMM_U: o_imm = {i_instr_bits[31:12], 12'b0};
            IMM_J: o_imm = {{11{i_instr_bits[31]}}, i_instr_bits[31], i_instr_bits[19:12],
                            i_instr_bits[20], i_instr_bits[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/stage_instruction_decode.sv
// Instruction-decode pipeline stage.
// Reads rs1/rs2 from a synchronous register file, builds the immediate and
// latches a decoded bundle for execute. Halts permanently on an illegal opcode.
//
// Optional feature macro: DECODE_WB_FORWARD_EN
//   defined   : a same-cycle writeback to a nonzero rs index is forwarded into
//               the latched operand instead of the register-file read data
//   undefined : wb_* inputs are ignored
//
// Ports
//   i_clock, i_reset_n            clock, async active-low reset
//   i_enable                      stage grant, held until o_is_complete
//   i_pc, i_instr_bits            fetched PC and instruction word
//   o_rf_r_addr_1/2, i_rf_r_data_1/2  register-file read ports
//   i_wb_enable/addr/data         writeback port (forwarding only)
//   o_is_complete                 one-cycle pulse, bundle latched on next edge
//   o_is_halted                   sticky illegal-instruction halt
//   o_dec_*                       latched decode bundle
//
// state    | meaning
// IDLE     | enable low, read counter reloaded
// READING  | enable high, counter > 0, waiting on register-file latency
// READY    | counter == 0, bundle latched on the completing edge
// HALTED   | illegal opcode seen, absorbing until reset
module stage_instruction_decode
    import stage_instruction_decode_pkg::*;
#(
    parameter int RF_READ_LATENCY = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [ILEN-1:0]      i_instr_bits,
    output logic [REG_IDX_W-1:0] o_rf_r_addr_1,
    output logic [REG_IDX_W-1:0] o_rf_r_addr_2,
    input  logic [XLEN-1:0]      i_rf_r_data_1,
    input  logic [XLEN-1:0]      i_rf_r_data_2,
    input  logic                 i_wb_enable,
    input  logic [REG_IDX_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]      i_wb_data,
    output logic                 o_is_complete,
    output logic                 o_is_halted,
    output opcode_t              o_dec_opcode,
    output logic [REG_IDX_W-1:0] o_dec_rd,
    output logic [2:0]           o_dec_funct3,
    output logic [6:0]           o_dec_funct7,
    output logic [XLEN-1:0]      o_dec_imm,
    output logic [XLEN-1:0]      o_dec_rs1_value,
    output logic [XLEN-1:0]      o_dec_rs2_value,
    output logic [XLEN-1:0]      o_dec_pc
);

    localparam int CNT_W = 2;

    logic [CNT_W-1:0] r_cnt;
    logic             r_halted;
    logic             r_done;

    opcode_t          w_opcode;
    imm_format_t      w_imm_format;
    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_rs1_value;
    logic [XLEN-1:0]  w_rs2_value;
    logic             w_read_done;
    logic             w_next_halted;
    logic             w_complete;

    assign o_rf_r_addr_1 = i_instr_bits[19:15];
    assign o_rf_r_addr_2 = i_instr_bits[24:20];

    assign w_opcode     = extract_opcode(i_instr_bits[6:0]);
    assign w_imm_format = imm_format_of(w_opcode);

    stage_instruction_decode_immediate_generator u_imm_gen (
        .i_instr_bits (i_instr_bits),
        .i_imm_format (w_imm_format),
        .o_imm        (w_imm)
    );

    assign w_read_done   = (r_cnt == '0);
    assign w_next_halted = r_halted | (i_enable & w_read_done & (w_opcode == OPCODE_UNKNOWN));
    // r_done keeps the pulse to one cycle when enable is held past completion.
    assign w_complete    = i_enable & w_read_done & ~r_done & ~r_halted & ~w_next_halted;
    assign o_is_complete = w_complete;
    assign o_is_halted   = r_halted;

    always_comb begin
        w_rs1_value = i_rf_r_data_1;
        w_rs2_value = i_rf_r_data_2;
`ifdef DECODE_WB_FORWARD_EN
        if (i_wb_enable && (i_wb_addr == o_rf_r_addr_1)) w_rs1_value = i_wb_data;
        if (i_wb_enable && (i_wb_addr == o_rf_r_addr_2)) w_rs2_value = i_wb_data;
`endif
        // x0 wins over both the register file and any forwarded value.
        if (o_rf_r_addr_1 == '0) w_rs1_value = '0;
        if (o_rf_r_addr_2 == '0) w_rs2_value = '0;
    end

`ifndef DECODE_WB_FORWARD_EN
    logic w_unused_wb;
    assign w_unused_wb = ^{i_wb_enable, i_wb_addr, i_wb_data};
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt    <= CNT_W'(RF_READ_LATENCY);
            r_halted <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_halted <= w_next_halted;
            if (!i_enable) begin
                r_cnt  <= CNT_W'(RF_READ_LATENCY);
                r_done <= 1'b0;
            end else begin
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                if (w_complete)  r_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_dec_opcode    <= OPCODE_UNKNOWN;
            o_dec_rd        <= '0;
            o_dec_funct3    <= '0;
            o_dec_funct7    <= '0;
            o_dec_imm       <= '0;
            o_dec_rs1_value <= '0;
            o_dec_rs2_value <= '0;
            o_dec_pc        <= '0;
        end else if (w_complete) begin
            o_dec_opcode    <= w_opcode;
            o_dec_rd        <= i_instr_bits[11:7];
            o_dec_funct3    <= i_instr_bits[14:12];
            o_dec_funct7    <= i_instr_bits[31:25];
            o_dec_imm       <= w_imm;
            o_dec_rs1_value <= w_rs1_value;
            o_dec_rs2_value <= w_rs2_value;
            o_dec_pc        <= i_pc;
        end
    end

endmodule

// File: tb/tb_stage_instruction_decode.sv
// Directed bench for stage_instruction_decode with RF_READ_LATENCY = 1.
module tb_stage_instruction_decode;
    import stage_instruction_decode_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [XLEN-1:0]      pc;
    logic [ILEN-1:0]      instr;
    logic [REG_IDX_W-1:0] rf_addr_1, rf_addr_2;
    logic [XLEN-1:0]      rf_data_1, rf_data_2;
    logic                 wb_enable;
    logic [REG_IDX_W-1:0] wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 is_complete, is_halted;
    opcode_t              dec_opcode;
    logic [REG_IDX_W-1:0] dec_rd;
    logic [2:0]           dec_funct3;
    logic [6:0]           dec_funct7;
    logic [XLEN-1:0]      dec_imm, dec_rs1, dec_rs2, dec_pc;

    int n_checks   = 0;
    int n_failures = 0;

    always #5 clk = ~clk;

    stage_instruction_decode #(.RF_READ_LATENCY(1)) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_enable        (enable),
        .i_pc            (pc),
        .i_instr_bits    (instr),
        .o_rf_r_addr_1   (rf_addr_1),
        .o_rf_r_addr_2   (rf_addr_2),
        .i_rf_r_data_1   (rf_data_1),
        .i_rf_r_data_2   (rf_data_2),
        .i_wb_enable     (wb_enable),
        .i_wb_addr       (wb_addr),
        .i_wb_data       (wb_data),
        .o_is_complete   (is_complete),
        .o_is_halted     (is_halted),
        .o_dec_opcode    (dec_opcode),
        .o_dec_rd        (dec_rd),
        .o_dec_funct3    (dec_funct3),
        .o_dec_funct7    (dec_funct7),
        .o_dec_imm       (dec_imm),
        .o_dec_rs1_value (dec_rs1),
        .o_dec_rs2_value (dec_rs2),
        .o_dec_pc        (dec_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles with current inputs, returns pulse count and the cycle of the first pulse.
    task automatic count_pulses(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= n; i++) begin
            cycle();
            if (is_complete) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    // One decode window: raise enable, expect a single pulse one cycle later, drop enable.
    task automatic run_window(input string tag, input logic [31:0] w, input logic [31:0] p);
        int pulses, first;
        instr  = w;
        pc     = p;
        enable = 1'b1;
        #1;
        check_eq({tag, "_no_early_complete"}, 32'(is_complete), 32'd0);
        count_pulses(4, pulses, first);
        check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, "_latency"}, 32'(first), 32'd1);
        enable = 1'b0;
        cycle();
    endtask

    logic [31:0] exp_fwd;
    int          pulses, first, halt_pulses;

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        pc        = '0;
        instr     = 32'h0000_0013;
        rf_data_1 = '0;
        rf_data_2 = '0;
        wb_enable = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        cycle();
        cycle();
        check_eq("rst_complete", 32'(is_complete), 32'd0);
        check_eq("rst_halted", 32'(is_halted), 32'd0);
        check_eq("rst_opcode", 32'(dec_opcode), 32'(OPCODE_UNKNOWN));
        check_eq("rst_imm", dec_imm, 32'd0);
        check_eq("rst_pc", dec_pc, 32'd0);
        rst_n = 1'b1;
        cycle();

        // addi x5, x1, -1
        rf_data_1 = 32'h10;
        rf_data_2 = 32'h20;
        instr     = 32'hFFF0_8293;
        #1;
        check_eq("addi_raddr1", 32'(rf_addr_1), 32'd1);
        check_eq("addi_raddr2", 32'(rf_addr_2), 32'd31);
        run_window("addi", 32'hFFF0_8293, 32'h100);
        check_eq("addi_imm", dec_imm, 32'hFFFF_FFFF);
        check_eq("addi_rs1", dec_rs1, 32'h10);
        check_eq("addi_rs2", dec_rs2, 32'h20);
        check_eq("addi_rd", 32'(dec_rd), 32'd5);
        check_eq("addi_opcode", 32'(dec_opcode), 32'(OPCODE_OP_IMM));
        check_eq("addi_pc", dec_pc, 32'h100);

        // beq x0, x0, -4 : x0 operands ignore the read data
        rf_data_1 = 32'hDEAD_BEEF;
        rf_data_2 = 32'hDEAD_BEEF;
        run_window("beq", 32'hFE00_0EE3, 32'h104);
        check_eq("beq_imm", dec_imm, 32'hFFFF_FFFC);
        check_eq("beq_rs1", dec_rs1, 32'd0);
        check_eq("beq_rs2", dec_rs2, 32'd0);
        check_eq("beq_opcode", 32'(dec_opcode), 32'(OPCODE_BRANCH));

        // sw x2, -12(x1)
        rf_data_1 = 32'h1111_0000;
        rf_data_2 = 32'h2222_0000;
        run_window("sw", 32'hFE20_AA23, 32'h108);
        check_eq("sw_imm", dec_imm, 32'hFFFF_FFF4);
        check_eq("sw_funct3", 32'(dec_funct3), 32'd2);
        check_eq("sw_funct7", 32'(dec_funct7), 32'h7F);
        check_eq("sw_rs2", dec_rs2, 32'h2222_0000);

        // jal x1, +2048
        run_window("jal", 32'h0010_00EF, 32'h10C);
        check_eq("jal_imm", dec_imm, 32'h0000_0800);
        check_eq("jal_rd", 32'(dec_rd), 32'd1);

        // enable glitch with no clock edge, then a real window (lui x7, 0x12345)
        instr  = 32'h1234_53B7;
        pc     = 32'h110;
        enable = 1'b1;
        #2;
        enable = 1'b0;
        cycle();
        check_eq("glitch_complete", 32'(is_complete), 32'd0);
        check_eq("glitch_hold_imm", dec_imm, 32'h0000_0800);
        check_eq("glitch_hold_pc", dec_pc, 32'h10C);
        run_window("lui", 32'h1234_53B7, 32'h110);
        check_eq("lui_imm", dec_imm, 32'h1234_5000);
        check_eq("lui_rd", 32'(dec_rd), 32'd7);
        check_eq("lui_opcode", 32'(dec_opcode), 32'(OPCODE_LUI));
        instr = 32'hFFF0_8293;
        pc    = 32'h999;
        cycle();
        cycle();
        check_eq("idle_hold_imm", dec_imm, 32'h1234_5000);
        check_eq("idle_hold_pc", dec_pc, 32'h110);

        // add x3, x1, x2 with a colliding writeback to x1
`ifdef DECODE_WB_FORWARD_EN
        exp_fwd = 32'hAA;
`else
        exp_fwd = 32'h55;
`endif
        rf_data_1 = 32'h55;
        rf_data_2 = 32'h66;
        wb_enable = 1'b1;
        wb_addr   = 5'd1;
        wb_data   = 32'hAA;
        run_window("add", 32'h0020_81B3, 32'h114);
        check_eq("add_rs1_fwd", dec_rs1, exp_fwd);
        check_eq("add_rs2", dec_rs2, 32'h66);
        check_eq("add_imm", dec_imm, 32'd0);
        check_eq("add_opcode", 32'(dec_opcode), 32'(OPCODE_OP));
        wb_enable = 1'b0;

        // reset asserted mid-read while the counter is still 1
        instr  = 32'hFFF0_8293;
        pc     = 32'h200;
        enable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_imm", dec_imm, 32'd0);
        check_eq("midrst_rd", 32'(dec_rd), 32'd0);
        check_eq("midrst_opcode", 32'(dec_opcode), 32'(OPCODE_UNKNOWN));
        check_eq("midrst_complete", 32'(is_complete), 32'd0);
        cycle();
        rst_n = 1'b1;
        #1;
        check_eq("midrst_restart_early", 32'(is_complete), 32'd0);
        count_pulses(3, pulses, first);
        check_eq("midrst_pulses", 32'(pulses), 32'd1);
        check_eq("midrst_latency", 32'(first), 32'd1);
        check_eq("midrst_pc", dec_pc, 32'h200);
        enable = 1'b0;
        cycle();

        // illegal all-zero word
        instr  = 32'h0;
        pc     = 32'h300;
        enable = 1'b1;
        cycle();
        check_eq("illegal_complete", 32'(is_complete), 32'd0);
        check_eq("illegal_halted_pre", 32'(is_halted), 32'd0);
        cycle();
        check_eq("illegal_halted", 32'(is_halted), 32'd1);
        check_eq("illegal_complete2", 32'(is_complete), 32'd0);
        halt_pulses = 0;
        for (int w = 0; w < 10; w++) begin
            enable = 1'b0;
            instr  = 32'h0000_0013;
            cycle();
            enable = 1'b1;
            count_pulses(3, pulses, first);
            halt_pulses += pulses;
            check_eq($sformatf("halt_sticky_w%0d", w), 32'(is_halted), 32'd1);
        end
        check_eq("halt_no_complete", 32'(halt_pulses), 32'd0);
        check_eq("halt_hold_pc", dec_pc, 32'h200);
        enable = 1'b0;

        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("halt_cleared", 32'(is_halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
